// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: binary-searches a 10-bit DAC trial code against an external comparator.
// Optional build macro SAR_AVG4_EN: one start runs four conversions and reports their truncated mean.
module sar_adc_ctrl #(
  parameter int NBITS         = 10,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_in,
  output logic             sample_hold,
  output logic [NBITS-1:0] dac_code,
  output logic [NBITS-1:0] dout,
  output logic             valid,
  output logic             busy
);
  localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;

  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    bit_q, bit_d;
  logic [3:0]       settle_q, settle_d;
  logic [NBITS-1:0] res_q, res_d;
  logic [NBITS-1:0] dac_q, dac_d;
  logic [NBITS-1:0] dout_q, dout_d;
  logic             sh_q, sh_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
`ifdef SAR_AVG4_EN
  logic [NBITS+1:0] acc_q, acc_d, acc_sum;
  logic [1:0]       conv_q, conv_d;
`endif

  logic [NBITS-1:0] trial, kept;
  logic             decide;

  assign trial  = NBITS'(1) << bit_q;
  assign kept   = cmp_in ? (res_q | trial) : res_q;
  assign decide = (settle_q == 4'(SETTLE_CYCLES));

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    settle_d = settle_q;
    res_d    = res_q;
    dac_d    = dac_q;
    dout_d   = dout_q;
    sh_d     = sh_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;
`ifdef SAR_AVG4_EN
    acc_d    = acc_q;
    conv_d   = conv_q;
    acc_sum  = acc_q + (NBITS+2)'(kept);
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SAMPLE;
          busy_d  = 1'b1;
          sh_d    = 1'b1;
          res_d   = '0;
`ifdef SAR_AVG4_EN
          acc_d   = '0;
          conv_d  = '0;
`endif
        end
      end
      SAMPLE: begin
        state_d  = CONVERT;
        sh_d     = 1'b0;
        bit_d    = IW'(NBITS-1);
        dac_d    = NBITS'(1) << (NBITS-1);
        settle_d = '0;
      end
      CONVERT: begin
        if (!decide) begin
          settle_d = settle_q + 4'd1;
        end else begin
          settle_d = '0;
          res_d    = kept;
          if (bit_q != '0) begin
            bit_d = bit_q - IW'(1);
            dac_d = kept | (trial >> 1);
          end else begin
            dac_d = kept;
`ifdef SAR_AVG4_EN
            acc_d = acc_sum;
            if (conv_q == 2'd3) begin
              dout_d  = acc_sum[NBITS+1:2];
              valid_d = 1'b1;
              busy_d  = 1'b0;
              state_d = DONE;
            end else begin
              // next conversion re-tracks the input immediately, no DONE/IDLE gap
              conv_d  = conv_q + 2'd1;
              res_d   = '0;
              sh_d    = 1'b1;
              state_d = SAMPLE;
            end
`else
            dout_d  = kept;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
`endif
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      bit_q    <= IW'(NBITS-1);
      settle_q <= '0;
      res_q    <= '0;
      dac_q    <= '0;
      dout_q   <= '0;
      sh_q     <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef SAR_AVG4_EN
      acc_q    <= '0;
      conv_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      settle_q <= settle_d;
      res_q    <= res_d;
      dac_q    <= dac_d;
      dout_q   <= dout_d;
      sh_q     <= sh_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
`ifdef SAR_AVG4_EN
      acc_q    <= acc_d;
      conv_q   <= conv_d;
`endif
    end
  end

  assign sample_hold = sh_q;
  assign dac_code    = dac_q;
  assign dout        = dout_q;
  assign valid       = valid_q;
  assign busy        = busy_q;

endmodule

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
- Successive-approximation ADC controller, the capture-side counterpart to the 10-bit DAC sine source.
- Drives a trial code into the 10-bit DAC and samples an external comparator. Binary-searches MSB to LSB and returns the digital code of the held input.
- Used to close the DAC/sine path in loopback: the sine output is sampled, converted back and compared to the generated codes.

Parameters:
- NBITS, 10, conversion resolution; also the width of dac_code and dout.
- SETTLE_CYCLES, 2, extra clocks the trial code is held before the comparator is sampled (DAC plus comparator settling). Legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request one conversion. Sampled only in IDLE.
- cmp_in  input  1  comparator result: 1 when Vin >= Vdac(dac_code).
- sample_hold  output  1  high for exactly one cycle while the input is tracked; low means hold.
- dac_code  output  NBITS  trial code to the DAC.
- dout  output  NBITS  last completed conversion result.
- valid  output  1  one-cycle pulse; dout is updated and valid for this cycle.
- busy  output  1  high from start acceptance until the valid cycle, not including the valid cycle.

Behaviour:
- Reset (async, any state): state=IDLE. sample_hold, dac_code, dout, valid and busy are all 0. Bit index=NBITS-1, settle counter=0. A reset mid-conversion discards the partial result.
- States: IDLE, SAMPLE, CONVERT, DONE.
- IDLE: start=1 at edge E0 -> SAMPLE, busy=1, sample_hold=1, working result cleared to 0.
- SAMPLE (1 cycle): at edge E1 -> CONVERT, sample_hold=0. Bit index=NBITS-1. dac_code=1<<(NBITS-1) (0x200). Settle counter=0.
- CONVERT: each bit occupies T=SETTLE_CYCLES+1 cycles with dac_code stable.
  - At the edge ending the bit's last cycle, cmp_in is registered.
  - If cmp_in=1, the trial bit is kept; if 0, it is cleared.
  - If the bit index > 0: decrement it and set dac_code=kept result | (1<<new index).
  - If the bit index = 0: dout=final result, dac_code=final result, valid=1, busy=0 -> DONE.
- DONE (1 cycle): valid=1. Next edge -> IDLE, valid=0.
- Latency: valid is registered at edge E1+NBITS*T, i.e. 31 clocks after the start edge with defaults.
- cmp_in is only sampled at bit-decision edges; its value at other times has no effect.
- start is ignored in SAMPLE, CONVERT and DONE (no queuing). Back-to-back conversions need one IDLE cycle, so the earliest restart is the cycle after DONE.
- Outside conversions: dac_code holds the last result; dout holds until the next valid.
- Boundaries:
  - cmp_in always 1 -> result 2^NBITS-1.
  - cmp_in always 0 -> result 0.
  - SETTLE_CYCLES=0 -> T=1, one decision per clock.
- Arithmetic is unsigned only; there is no overflow path.

Optional Feature:
- Macro: SAR_AVG4_EN.
- Defined:
  - One start runs four consecutive conversions. After each final bit, the next conversion enters SAMPLE directly instead of DONE.
  - Results are summed in an (NBITS+2)-bit accumulator, cleared at start acceptance.
  - dout=sum[NBITS+1:2], truncated.
  - valid pulses once after the fourth conversion, at edge E0+4*(1+NBITS*T) (124 with defaults).
  - busy stays high across all four conversions.
  - sample_hold pulses once per conversion.
- Undefined: a single conversion per start as described above, with no accumulator logic present.

Test Plan:
- Bench comparator model: cmp_in = (vin_code >= dac_code).
  - vin_code=0x2A5, start pulse -> dout=0x2A5.
  - valid exactly 31 clocks after the start edge.
  - dac_code sequence begins 0x200, 0x300, 0x280, 0x2C0.
- vin_code=0x000 -> dout=0x000. vin_code=0x3FF -> dout=0x3FF. Each result has exactly one valid pulse and busy low during the valid cycle.
- start held high continuously with vin_code=0x155:
  - conversions repeat with one IDLE cycle between each;
  - every dout=0x155;
  - start pulses during busy produce no extra conversion.
- Assert rst at clock 12 of a conversion:
  - all outputs 0 immediately (asynchronous, before the next edge);
  - after release, a new start with vin_code=0x0F0 gives dout=0x0F0.
- SETTLE_CYCLES=0, vin_code=0x001 -> dout=0x001 with valid 11 clocks after the start edge. SETTLE_CYCLES=5 -> valid 61 clocks after the start edge.
- SAR_AVG4_EN defined, vin_code changed per conversion to 0x100, 0x101, 0x102, 0x104 (sum 0x407) -> dout=0x101. Single valid pulse 124 clocks after start, with 4 sample_hold pulses.
